// File: rtl/cell_op_engine.sv
// Cell-processor responder: watches free-running operand cells, and when they change computes a
// per-pixel, per-channel result one pixel per clock, then publishes it with a one-cycle valid strobe.
module cell_op_engine #(
    parameter int PIXELS  = 9,
    parameter int PIXEL_W = 24
) (
    input  logic                        SYSCLK,
    input  logic                        RST,
    input  logic [PIXELS*PIXEL_W-1:0]   cell_a,
    input  logic [PIXELS*PIXEL_W-1:0]   cell_b,
    input  logic [3:0]                  opcode,
    output logic [PIXELS*PIXEL_W-1:0]   result_cell,
    output logic                        result_valid,
    output logic                        busy
);

    localparam int CELL_W = PIXELS * PIXEL_W;
    localparam int CHANS  = PIXEL_W / 8;
    localparam int IDX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        PROC,
        DONE
    } state_t;

    state_t             state_reg;
    logic [CELL_W-1:0]  cap_a_reg;
    logic [CELL_W-1:0]  cap_b_reg;
    logic [3:0]         cap_op_reg;
    logic               primed_reg;
    logic [IDX_W-1:0]   pix_idx_reg;
    logic [CELL_W-1:0]  shadow_reg;

    logic [CELL_W-1:0]  merged;
    logic [PIXEL_W-1:0] pix_a;
    logic [PIXEL_W-1:0] pix_b;
    logic [PIXEL_W-1:0] pix_res;
    logic               start;

    // Unsigned 8-bit channel operation; sums and differences are taken at 9 bits.
    function automatic logic [7:0] chan_op(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        logic [8:0] sum;
        logic [8:0] diff;
        logic [7:0] res;
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        case (op)
            4'd1:    res = b;
            4'd2:    res = sum[8] ? 8'hFF : sum[7:0];
            4'd3:    res = diff[8] ? 8'h00 : diff[7:0];
            4'd4:    res = a & b;
            4'd5:    res = a | b;
            4'd6:    res = a ^ b;
            4'd7:    res = ~a;
            4'd8:    res = sum[8:1];
            4'd9:    res = (a < b) ? a : b;
            4'd10:   res = (a > b) ? a : b;
            default: res = a;
        endcase
        return res;
    endfunction

    assign start = !primed_reg || (cell_a != cap_a_reg) || (cell_b != cap_b_reg)
                   || (opcode != cap_op_reg);

    assign pix_a = cap_a_reg[pix_idx_reg*PIXEL_W +: PIXEL_W];
    assign pix_b = cap_b_reg[pix_idx_reg*PIXEL_W +: PIXEL_W];

    genvar gi;
    generate
        for (gi = 0; gi < CHANS; gi++) begin : g_chan
            assign pix_res[gi*8 +: 8] = chan_op(pix_a[gi*8 +: 8], pix_b[gi*8 +: 8], cap_op_reg);
        end
        // Shadow with the current pixel slotted in, so the last pixel can go straight to the output.
        for (gi = 0; gi < PIXELS; gi++) begin : g_merge
            assign merged[gi*PIXEL_W +: PIXEL_W] = (pix_idx_reg == IDX_W'(gi)) ? pix_res
                                                   : shadow_reg[gi*PIXEL_W +: PIXEL_W];
        end
    endgenerate

    always_ff @(posedge SYSCLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            cap_a_reg    <= '0;
            cap_b_reg    <= '0;
            cap_op_reg   <= '0;
            primed_reg   <= 1'b0;
            pix_idx_reg  <= '0;
            shadow_reg   <= '0;
            result_cell  <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= CAPTURE;
                        busy      <= 1'b1;
                    end
                end
                CAPTURE: begin
                    cap_a_reg   <= cell_a;
                    cap_b_reg   <= cell_b;
                    cap_op_reg  <= opcode;
                    primed_reg  <= 1'b1;
                    pix_idx_reg <= '0;
                    state_reg   <= PROC;
                end
                PROC: begin
                    shadow_reg <= merged;
                    if (pix_idx_reg == LAST_IDX) begin
                        pix_idx_reg  <= '0;
                        result_cell  <= merged;
                        result_valid <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        pix_idx_reg <= pix_idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_op_engine.sv
// Scoreboard bench for cell_op_engine: directed jobs push expected cells, and a monitor pops and
// compares on every result_valid pulse.
module tb_cell_op_engine;

    localparam int PIXELS  = 9;
    localparam int PIXEL_W = 24;
    localparam int CELL_W  = PIXELS * PIXEL_W;

    logic              SYSCLK = 1'b0;
    logic              RST;
    logic [CELL_W-1:0] cell_a;
    logic [CELL_W-1:0] cell_b;
    logic [3:0]        opcode;
    logic [CELL_W-1:0] result_cell;
    logic              result_valid;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int valid_cnt = 0;
    int release_edge = 0;
    logic [CELL_W-1:0] sb[$];
    int valid_edges[$];

    cell_op_engine #(.PIXELS(PIXELS), .PIXEL_W(PIXEL_W)) dut (
        .SYSCLK       (SYSCLK),
        .RST          (RST),
        .cell_a       (cell_a),
        .cell_b       (cell_b),
        .opcode       (opcode),
        .result_cell  (result_cell),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 SYSCLK = ~SYSCLK;

    always @(posedge SYSCLK) edge_cnt <= edge_cnt + 1;

    function automatic logic [CELL_W-1:0] fill(input logic [PIXEL_W-1:0] pix);
        logic [CELL_W-1:0] c;
        for (int i = 0; i < PIXELS; i++) c[i*PIXEL_W +: PIXEL_W] = pix;
        return c;
    endfunction

    task automatic check(input string name, input logic [CELL_W-1:0] act,
                         input logic [CELL_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge SYSCLK) begin
        if (RST === 1'b1 && result_valid === 1'b1) begin
            valid_cnt++;
            valid_edges.push_back(edge_cnt);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at edge %0d actual=%h required=no pulse",
                         edge_cnt, result_cell);
            end else begin
                check("result_cell", result_cell, sb.pop_front());
                check("busy_with_valid", CELL_W'(busy), CELL_W'(1));
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge SYSCLK);
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge SYSCLK);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=%0d pending required=0 pending", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge SYSCLK);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s busy_timeout actual=0 required=1", name);
        end
    endtask

    task automatic run_job(input string name, input logic [CELL_W-1:0] a,
                           input logic [CELL_W-1:0] b, input logic [3:0] op,
                           input logic [CELL_W-1:0] exp);
        $display("job  %s op=%0d", name, op);
        sb.push_back(exp);
        cell_a = a;
        cell_b = b;
        opcode = op;
        wait_idle(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CELL_W-1:0] sat_a, sat_b, a2;
        int n0, v0;
        bit busy_seen;

        RST    = 1'b0;
        cell_a = fill(24'hFFFFFF);
        cell_b = '0;
        opcode = 4'd0;
        repeat (3) @(negedge SYSCLK);
        check("reset_result", result_cell, '0);
        check("reset_valid", CELL_W'(result_valid), CELL_W'(0));
        check("reset_busy", CELL_W'(busy), CELL_W'(0));

        // First job starts from primed=0 on the first cycle after release.
        sb.push_back(fill(24'hFFFFFF));
        RST = 1'b1;
        release_edge = edge_cnt;
        wait_idle("first_job");
        check("first_pulses", CELL_W'(valid_edges.size()), CELL_W'(1));
        check("first_latency", CELL_W'(valid_edges[0] - release_edge), CELL_W'(11));

        run_job("or",  fill(24'hFF0000), fill(24'h00FF00), 4'd5, fill(24'hFFFF00));
        run_job("and", fill(24'hFF0000), fill(24'h00FF00), 4'd4, fill(24'h000000));

        sat_a = fill(24'hF08010);
        sat_b = fill(24'h20A030);
        run_job("sat_add",  sat_a, sat_b, 4'd2,  fill(24'hFFFF40));
        run_job("sat_sub",  sat_a, sat_b, 4'd3,  fill(24'hD00000));
        run_job("average",  sat_a, sat_b, 4'd8,  fill(24'h889020));
        run_job("min",      sat_a, sat_b, 4'd9,  fill(24'h208010));
        run_job("max",      sat_a, sat_b, 4'd10, fill(24'hF0A030));
        run_job("xor",      sat_a, sat_b, 4'd6,  fill(24'hD02020));
        run_job("not_a",    sat_a, sat_b, 4'd7,  fill(24'h0F7FEF));
        run_job("pass_b",   sat_a, sat_b, 4'd1,  fill(24'h20A030));
        run_job("op13",     sat_a, sat_b, 4'd13, fill(24'hF08010));

        // Change during a job: current job unaffected, second job follows with the new value.
        n0 = valid_edges.size();
        sb.push_back(fill(24'h112233));
        cell_a = fill(24'h112233);
        cell_b = '0;
        opcode = 4'd0;
        wait_busy("midjob");
        repeat (3) @(negedge SYSCLK);
        a2 = fill(24'h112233);
        a2[4*PIXEL_W +: PIXEL_W] = 24'h0000FF;
        sb.push_back(a2);
        cell_a = a2;
        wait_idle("midjob");
        check("midjob_pulses", CELL_W'(valid_edges.size() - n0), CELL_W'(2));
        // DONE, one IDLE re-evaluation cycle, then the usual 11-cycle latency.
        if (valid_edges.size() >= n0 + 2)
            check("midjob_gap", CELL_W'(valid_edges[n0+1] - valid_edges[n0]), CELL_W'(PIXELS + 3));

        // Stable inputs must never retrigger.
        v0 = valid_cnt;
        busy_seen = 1'b0;
        repeat (100) begin
            @(negedge SYSCLK);
            if (busy) busy_seen = 1'b1;
        end
        check("stable_no_pulse", CELL_W'(valid_cnt - v0), CELL_W'(0));
        check("stable_busy_low", CELL_W'(busy_seen), CELL_W'(0));

        // Reset in the middle of PROC at pix_idx 5.
        cell_a = fill(24'h010203);
        @(negedge SYSCLK);
        wait_busy("reset_mid");
        repeat (6) @(posedge SYSCLK);
        @(negedge SYSCLK);
        RST = 1'b0;
        #1;
        check("midreset_result", result_cell, '0);
        check("midreset_valid", CELL_W'(result_valid), CELL_W'(0));
        check("midreset_busy", CELL_W'(busy), CELL_W'(0));
        repeat (2) @(negedge SYSCLK);
        n0 = valid_edges.size();
        sb.push_back(fill(24'h010203));
        RST = 1'b1;
        release_edge = edge_cnt;
        wait_idle("rerun");
        check("rerun_pulses", CELL_W'(valid_edges.size() - n0), CELL_W'(1));
        if (valid_edges.size() > n0)
            check("rerun_latency", CELL_W'(valid_edges[n0] - release_edge), CELL_W'(11));

        repeat (20) @(negedge SYSCLK);
        check("queue_drained", CELL_W'(sb.size()), CELL_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
